qmf_recon_checker: RTL and testbench
====================================

# qmf_recon_checker

Synthesizable reconstruction checker for the QMF core chain (analysis -> synthesis). It consumes the same sample stream that drives the analysis core plus the reconstructed output of the synthesis core. It aligns the two with a programmable latency and compares them over a fixed window, reporting maximum absolute error, out-of-tolerance count and a pass flag. It sits beside the QMF system as the in-hardware counterpart of the stimulus/logging bench, for on-board self-test.

## Interface
- DATAW, 16, sample width (signed, matches QMF cores)
- MAX_LAT, 64, delay-buffer depth; power of 2; LATW = clog2(MAX_LAT)
- NSAMP, 1000, number of compared samples per run
- TOL, 64, allowed absolute error (unsigned, inclusive)
- CNTW, 16, width of error and sample counters
- clk  in  1  system clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- en  in  1  sample strobe, same as the QMF cores' en; all state advances only when en=1
- start  in  1  single-cycle run request
- latency  in  LATW  alignment delay in en-samples (0..MAX_LAT-1), sampled on accepted start
- din  in  DATAW  original signed input sample (analysis core input)
- dout_recon  in  DATAW  signed reconstructed sample (synthesis core output)
- busy  out  1  run in progress (PRIME or CHECK)
- done  out  1  run complete, results valid; held until next accepted start
- pass  out  1  1 when done and err_count==0
- max_err  out  DATAW+1  largest |dout_recon - ref| seen in CHECK
- err_count  out  CNTW  samples with |err| > TOL, saturating
- sample_count  out  CNTW  samples compared so far in current run

## Operation
- Delay buffer: circular RAM of MAX_LAT x DATAW; write din at wr_ptr and increment (mod MAX_LAT) on every en=1 cycle in every state, including IDLE.
- Reference: ref = buffer[(wr_ptr - lat_q) mod MAX_LAT] read before the write; lat_q=0 selects din directly (bypass).
- Error: err = dout_recon - ref computed at DATAW+1 bits signed; abs_err = |err| at DATAW+1 bits unsigned, with no overflow possible.
- FSM states:
  - IDLE -> PRIME on start when lat_q != 0, or straight to CHECK when lat_q == 0.
  - PRIME counts lat_q en-cycles, then -> CHECK.
  - CHECK compares NSAMP en-cycles, then -> DONE.
  - DONE -> PRIME/CHECK on start.
- Accepted start (IDLE or DONE only): capture latency into lat_q; clear max_err, err_count, sample_count, done, pass.
- start while busy: ignored, no effect on run or latched latency.
- CHECK, per en=1 cycle: sample_count+1; max_err = max(max_err, abs_err); err_count+1 if abs_err > TOL, saturating at 2^CNTW-1.
- When the NSAMP-th comparison registers: enter DONE, assert done, and set pass = (final err_count == 0).
- en=0 in any state: hold FSM, counters, pointer and buffer; no comparison.

## Timing
- All outputs registered. Reset values: busy=0, done=0, pass=0, max_err=0, err_count=0, sample_count=0, state IDLE, wr_ptr=0. Buffer contents are don't-care.
- Start accepted at edge T; busy=1 from T+1.
- First compared sample is the (lat_q+1)-th en-sample after start; with lat_q=0, it is the first en-sample after start.
- Statistics update at the same edge the sample is compared (1-cycle latency to outputs).
- With en tied high, done rises exactly lat_q+NSAMP cycles after the start edge, and busy falls on the same edge.
- start coinciding with the final CHECK edge: ignored (still busy).
- Reset mid-run: immediate return to reset values; buffer history is lost and not re-validated.

## Test plan
- Identity: dout_recon=din, latency=0, NSAMP=1000, en=1 -> done after 1000 cycles, pass=1, max_err=0, err_count=0, sample_count=1000.
- Pure delay: dout_recon = din delayed 7 samples (sine, amplitude 10000, Fs/50), latency=7 -> pass=1, max_err=0. Same stream with latency=6 -> pass=0, err_count>0.
- Tolerance edge: dout_recon = delayed din +64 on one sample and +65 on another -> err_count=1, max_err=65, pass=0.
- Extreme swing: ref=-32768, dout_recon=32767 -> max_err=65535 (17-bit), no wrap.
- Stall: en toggled 1010..., latency=3 -> identical results to en=1, with done arriving at twice the cycle count. start pulsed mid-run -> ignored.
- Reset and saturation: assert rstn=0 mid-CHECK -> all outputs 0, IDLE; then rerun with CNTW=4 and every sample erroneous -> err_count=15, pass=0.

Source files
------------

// File: rtl/qmf_recon_checker.sv
// qmf_recon_checker
// -----------------------------------------------------------------------------
// On-board reconstruction checker for the QMF analysis -> synthesis chain.
// The original sample stream (din) is written into a circular delay buffer on
// every en strobe. A run aligns din by a programmable latency and compares it
// against the reconstructed stream (dout_recon) for NSAMP samples. The run
// reports the largest absolute error, the number of out-of-tolerance samples
// and a pass flag.
//
// Ports
//   clk          in   system clock
//   rstn         in   asynchronous active-low reset
//   en           in   sample strobe; all state advances only when en=1
//   start        in   single-cycle run request (honoured in IDLE/DONE only)
//   latency      in   alignment delay in en-samples, captured on accepted start
//   din          in   original signed sample (analysis core input)
//   dout_recon   in   reconstructed signed sample (synthesis core output)
//   busy         out  run in progress (PRIME or CHECK)
//   done         out  run complete, results valid until next accepted start
//   pass         out  done and no out-of-tolerance sample
//   max_err      out  largest |dout_recon - ref| seen in CHECK (DATAW+1 bits)
//   err_count    out  samples with |err| > TOL, saturating
//   sample_count out  samples compared in the current run, saturating
// -----------------------------------------------------------------------------
module qmf_recon_checker #(
    parameter int DATAW   = 16,
    parameter int MAX_LAT = 64,
    parameter int NSAMP   = 1000,
    parameter int TOL     = 64,
    parameter int CNTW    = 16,
    parameter int LATW    = $clog2(MAX_LAT)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             start,
    input  logic [LATW-1:0]  latency,
    input  logic [DATAW-1:0] din,
    input  logic [DATAW-1:0] dout_recon,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [DATAW:0]   max_err,
    output logic [CNTW-1:0]  err_count,
    output logic [CNTW-1:0]  sample_count
);

    localparam int ERRW = DATAW + 1;
    // The run counter is sized for NSAMP independently of CNTW so that a
    // narrow statistics width cannot cut the comparison window short.
    localparam int RUNW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam logic [RUNW-1:0] LAST_RUN = RUNW'(NSAMP - 1);
    localparam logic [ERRW-1:0] TOL_V    = ERRW'(TOL);
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // |a - b| of two signed samples. One guard bit keeps the full range
    // (-2^(DATAW-1) vs 2^(DATAW-1)-1) representable without wrap.
    function automatic logic [ERRW-1:0] abs_diff(input logic [DATAW-1:0] a,
                                                 input logic [DATAW-1:0] b);
        logic signed [ERRW-1:0] d;
        d = $signed({a[DATAW-1], a}) - $signed({b[DATAW-1], b});
        if (d[ERRW-1]) begin
            abs_diff = $unsigned(-d);
        end else begin
            abs_diff = $unsigned(d);
        end
    endfunction

    logic [DATAW-1:0] mem [MAX_LAT];

    state_t           state_q, state_d;
    logic [LATW-1:0]  wr_ptr_q;
    logic [LATW-1:0]  lat_q, lat_d;
    logic [LATW-1:0]  prime_cnt_q, prime_cnt_d;
    logic [RUNW-1:0]  run_cnt_q, run_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERRW-1:0]  max_err_q, max_err_d;
    logic [CNTW-1:0]  err_cnt_q, err_cnt_d;
    logic [CNTW-1:0]  smp_cnt_q, smp_cnt_d;

    logic [LATW-1:0]  rd_idx_s;
    logic [DATAW-1:0] ref_sample_s;
    logic [ERRW-1:0]  abs_err_s;

    // Reference tap: read before this cycle's write; latency 0 bypasses the RAM.
    assign rd_idx_s     = wr_ptr_q - lat_q;
    assign ref_sample_s = (lat_q == {LATW{1'b0}}) ? din : mem[rd_idx_s];
    assign abs_err_s    = abs_diff(dout_recon, ref_sample_s);

    // Delay-line storage: written on every strobe regardless of run state.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Next-state and statistics update for the run FSM.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        prime_cnt_d = prime_cnt_q;
        run_cnt_d   = run_cnt_q;
        pass_d      = pass_q;
        max_err_d   = max_err_q;
        err_cnt_d   = err_cnt_q;
        smp_cnt_d   = smp_cnt_q;

        if (en) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        lat_d       = latency;
                        prime_cnt_d = {LATW{1'b0}};
                        run_cnt_d   = {RUNW{1'b0}};
                        pass_d      = 1'b0;
                        max_err_d   = {ERRW{1'b0}};
                        err_cnt_d   = CNT_ZERO;
                        smp_cnt_d   = CNT_ZERO;
                        if (latency == {LATW{1'b0}}) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_PRIME;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_PRIME: begin
                    // lat_q is non-zero here, so lat_q-1 never underflows.
                    if (prime_cnt_q == (lat_q - LATW'(1))) begin
                        state_d = ST_CHECK;
                    end else begin
                        prime_cnt_d = prime_cnt_q + LATW'(1);
                    end
                end
                ST_CHECK: begin
                    run_cnt_d = run_cnt_q + RUNW'(1);
                    if (smp_cnt_q != CNT_MAX) begin
                        smp_cnt_d = smp_cnt_q + CNTW'(1);
                    end else begin
                        smp_cnt_d = smp_cnt_q;
                    end
                    if (abs_err_s > max_err_q) begin
                        max_err_d = abs_err_s;
                    end else begin
                        max_err_d = max_err_q;
                    end
                    if ((abs_err_s > TOL_V) && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + CNTW'(1);
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    // pass uses the count including this final sample.
                    if (run_cnt_q == LAST_RUN) begin
                        state_d = ST_DONE;
                        pass_d  = (err_cnt_d == CNT_ZERO);
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d == ST_PRIME) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {LATW{1'b0}};
            lat_q       <= {LATW{1'b0}};
            prime_cnt_q <= {LATW{1'b0}};
            run_cnt_q   <= {RUNW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            max_err_q   <= {ERRW{1'b0}};
            err_cnt_q   <= CNT_ZERO;
            smp_cnt_q   <= CNT_ZERO;
        end else begin
            if (en) begin
                wr_ptr_q <= wr_ptr_q + LATW'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            state_q     <= state_d;
            lat_q       <= lat_d;
            prime_cnt_q <= prime_cnt_d;
            run_cnt_q   <= run_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            max_err_q   <= max_err_d;
            err_cnt_q   <= err_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign max_err      = max_err_q;
    assign err_count    = err_cnt_q;
    assign sample_count = smp_cnt_q;

endmodule

// File: tb/tb_qmf_recon_checker.sv
// tb_qmf_recon_checker
// -----------------------------------------------------------------------------
// Scoreboard bench for qmf_recon_checker. Each run computes its expected
// statistics from the stimulus functions, pushes them into a queue when the
// start is driven, and pops/compares them when done rises. A second instance
// with CNTW=4 / NSAMP=20 covers counter saturation.
// -----------------------------------------------------------------------------
module tb_qmf_recon_checker;

    localparam int LATW = 6;

    typedef struct {
        string  tag;
        longint max_err;
        longint err_cnt;
        longint samp;
        longint pass;
        longint cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            en;
    logic            start;
    logic            start_sat;
    logic [LATW-1:0] latency;
    logic [15:0]     din;
    logic [15:0]     dout_recon;

    logic            busy_m, done_m, pass_m;
    logic [16:0]     max_err_m;
    logic [15:0]     err_count_m, sample_count_m;
    logic            busy_s, done_s, pass_s;
    logic [16:0]     max_err_s;
    logic [3:0]      err_count_s, sample_count_s;

    logic            sel_sat;
    logic            o_busy, o_done, o_pass;
    logic [16:0]     o_max_err;
    logic [15:0]     o_err_count, o_sample_count;

    exp_t            sb_q[$];
    int              n_checks = 0;
    int              n_pass   = 0;
    int              gn;
    int              run_base;
    int              cur_mode;

    qmf_recon_checker u_dut (
        .clk(clk), .rstn(rstn), .en(en), .start(start), .latency(latency),
        .din(din), .dout_recon(dout_recon),
        .busy(busy_m), .done(done_m), .pass(pass_m), .max_err(max_err_m),
        .err_count(err_count_m), .sample_count(sample_count_m)
    );

    qmf_recon_checker #(.NSAMP(20), .CNTW(4)) u_sat (
        .clk(clk), .rstn(rstn), .en(en), .start(start_sat), .latency(latency),
        .din(din), .dout_recon(dout_recon),
        .busy(busy_s), .done(done_s), .pass(pass_s), .max_err(max_err_s),
        .err_count(err_count_s), .sample_count(sample_count_s)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (sel_sat) begin
            o_busy = busy_s; o_done = done_s; o_pass = pass_s;
            o_max_err = max_err_s;
            o_err_count = {12'd0, err_count_s};
            o_sample_count = {12'd0, sample_count_s};
        end else begin
            o_busy = busy_m; o_done = done_m; o_pass = pass_m;
            o_max_err = max_err_m;
            o_err_count = err_count_m;
            o_sample_count = sample_count_m;
        end
    end

    task automatic check_val(input string tag, input longint obs, input longint exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    // Original stream as a function of the global en-sample index.
    function automatic int din_f(input int mode, input int n);
        case (mode)
            0:       return ((n * 40503) & 32'hFFFF) - 32768;
            1, 2:    return int'(10000.0 * $sin(2.0 * 3.141592653589793 * n / 50.0));
            3:       return -32768;
            4:       return 0;
            5:       return ((n * 40503) & 32'h7FFF) - 16384;
            default: return 0;
        endcase
    endfunction

    // Reconstructed stream for each scenario.
    function automatic int recon_f(input int mode, input int n);
        case (mode)
            0:       return din_f(0, n);
            1:       return din_f(1, n - 7);
            2:       return din_f(2, n - 7) + ((n - run_base) == 100 ? 64 :
                                               (n - run_base) == 300 ? 65 : 0);
            3:       return 32767;
            4:       return 1000;
            5:       return din_f(5, n - 3) + ((n % 37) == 0 ? 100 : 0);
            default: return 0;
        endcase
    endfunction

    function automatic exp_t exp_calc(input string tag, input int mode, input int lat,
                                      input int nsamp, input int cntw, input bit stall);
        exp_t e;
        longint d, mx, cnt, cap;
        int n;
        mx = 0; cnt = 0;
        cap = (longint'(1) << cntw) - 1;
        for (int i = 1; i <= nsamp; i++) begin
            n = run_base + lat + i;
            d = longint'(recon_f(mode, n)) - longint'(din_f(mode, n - lat));
            if (d < 0) d = -d;
            if (d > mx) mx = d;
            if (d > 64 && cnt < cap) cnt++;
        end
        e.tag = tag; e.max_err = mx; e.err_cnt = cnt;
        e.samp = (nsamp < cap) ? nsamp : cap;
        e.pass = (cnt == 0) ? 1 : 0;
        e.cyc  = (stall ? 2 : 1) * (lat + nsamp);
        return e;
    endfunction

    // Drive one cycle's inputs, advance past the edge, land 1 time unit after it.
    task automatic tick(input bit en_v);
        en = en_v;
        if (en_v) begin
            din        = 16'(din_f(cur_mode, gn));
            dout_recon = 16'(recon_f(cur_mode, gn));
        end else begin
            din        = 16'($urandom);
            dout_recon = 16'($urandom);
        end
        @(posedge clk);
        #1;
        if (en_v) gn++;
    endtask

    task automatic run(input string tag, input int mode, input int lat, input bit stall,
                       input bit use_sat, input bit pulse_mid, input bit hit_final);
        exp_t e, got;
        int k;
        cur_mode = mode;
        run_base = gn;
        sel_sat  = use_sat;
        e = exp_calc(tag, mode, lat, use_sat ? 20 : 1000, use_sat ? 4 : 16, stall);
        sb_q.push_back(e);
        latency = LATW'(lat);
        if (use_sat) start_sat = 1'b1;
        else start = 1'b1;
        tick(1'b1);
        start = 1'b0; start_sat = 1'b0;
        check_val({tag, "_busy_rise"}, o_busy, 1);
        check_val({tag, "_done_clr"}, o_done, 0);
        k = 0;
        while (!o_done && k < e.cyc + 20) begin
            k++;
            if (pulse_mid && k == 200) begin start = 1'b1; latency = 6'd5; end
            if (hit_final && k == e.cyc) begin start = 1'b1; latency = 6'd9; end
            tick(stall ? ((k % 2) == 0) : 1'b1);
            start = 1'b0;
        end
        got = sb_q.pop_front();
        check_val({got.tag, "_cycles"}, k, got.cyc);
        check_val({got.tag, "_done"}, o_done, 1);
        check_val({got.tag, "_busy_fall"}, o_busy, 0);
        check_val({got.tag, "_max_err"}, o_max_err, got.max_err);
        check_val({got.tag, "_err_count"}, o_err_count, got.err_cnt);
        check_val({got.tag, "_sample_count"}, o_sample_count, got.samp);
        check_val({got.tag, "_pass"}, o_pass, got.pass);
        tick(1'b1);
        check_val({got.tag, "_done_held"}, o_done, 1);
        check_val({got.tag, "_idle_after"}, o_busy, 0);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_busy"}, o_busy, 0);
        check_val({tag, "_done"}, o_done, 0);
        check_val({tag, "_pass"}, o_pass, 0);
        check_val({tag, "_max_err"}, o_max_err, 0);
        check_val({tag, "_err_count"}, o_err_count, 0);
        check_val({tag, "_sample_count"}, o_sample_count, 0);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; start = 1'b0; start_sat = 1'b0;
        latency = 6'd0; din = 16'd0; dout_recon = 16'd0;
        sel_sat = 1'b0; gn = 0; run_base = 0; cur_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rstn = 1'b1;
        repeat (3) tick(1'b1);

        run("identity", 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("identity_maxerr_zero", o_max_err, 0);
        run("delay7", 1, 7, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("delay7_pass", o_pass, 1);
        run("delay6", 1, 6, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("delay6_errs_nonzero", (o_err_count > 0) ? 1 : 0, 1);
        run("tol_edge", 2, 7, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("tol_edge_max65", o_max_err, 65);
        run("extreme", 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("extreme_max65535", o_max_err, 65535);
        run("stall", 5, 3, 1'b1, 1'b0, 1'b1, 1'b0);
        run("nostall", 5, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a CHECK window.
        cur_mode = 0; sel_sat = 1'b0; latency = 6'd0; start = 1'b1;
        tick(1'b1);
        start = 1'b0;
        repeat (300) tick(1'b1);
        check_val("midrun_busy", o_busy, 1);
        check_val("midrun_samples", o_sample_count, 300);
        rstn = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) tick(1'b1);
        rstn = 1'b1;
        repeat (2) tick(1'b1);
        check_zero("post_reset_idle");

        run("saturate", 4, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("saturate_err15", o_err_count, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
